dma_csr_slave: RTL and testbench

AXI-Lite slave that implements the DMA controller's register map and drives the DMA transfer engine. It holds SRC_ADDR, DST_ADDR, LENGTH, CONTROL, STATUS and BURST. It turns a CONTROL.Start write into a one-cycle start pulse toward the engine. It collects the engine's done/error events into STATUS and raises the interrupt. It sits between the system AXI-Lite interconnect (upstream) and the DMA datapath engine (downstream).

---
 rtl/dma_csr_slave_if.sv | 32 +++
 rtl/dma_csr_slave.sv | 226 ++++++++++++++++++++++
 tb/tb_dma_csr_slave.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dma_csr_slave_if.sv
// AXI-Lite bundle between the interconnect (master) and the DMA CSR block (slave).
interface dma_csr_slave_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/dma_csr_slave.sv
// DMA controller register file behind an AXI-Lite slave port.
// Holds SRC/DST/LEN/CONTROL/STATUS/BURST, turns CONTROL.start into a one-cycle
// engine start pulse and folds engine done/err events into STATUS and irq.
// Optional feature macro: DMA_CSR_WSTRB_EN (per-byte write strobes on RW registers).
module dma_csr_slave #(
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dma_csr_slave_if.slave        s_axil,
    output logic [31:0]           dma_src,
    output logic [31:0]           dma_dst,
    output logic [31:0]           dma_len,
    output logic [1:0]            dma_burst,
    output logic                  dma_start,
    input  logic                  dma_busy,
    input  logic                  dma_done,
    input  logic                  dma_err,
    output logic                  irq
);
    localparam int          DATA_W      = 32;
    localparam int          IW          = ADDR_W - 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Register state
    logic [DATA_W-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic [1:0]        burst_q, burst_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d, err_q, err_d;
    logic              irq_q, start_q, start_d;

    // Write channel buffers and response
    logic              aw_held_q, w_held_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q, wr_resp;

    // Read channel
    logic              rvalid_q;
    logic [1:0]        rresp_q, rd_resp;
    logic [DATA_W-1:0] rdata_q, rd_val;

    logic              aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data, wmask;
    logic [3:0]        wr_strb;
    logic [IW-1:0]     wr_idx, rd_idx;
    logic              wr_map, rd_map, start_en;
    logic              clr_status, set_err_cmd;

    assign s_axil.awready = !aw_held_q && !bvalid_q;
    assign s_axil.wready  = !w_held_q && !bvalid_q;
    assign s_axil.arready = !rvalid_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rdata_q;

    assign dma_src   = src_q;
    assign dma_dst   = dst_q;
    assign dma_len   = len_q;
    assign dma_burst = burst_q;
    assign dma_start = start_q;
    assign irq       = irq_q;

    assign aw_hs = s_axil.awvalid && s_axil.awready;
    assign w_hs  = s_axil.wvalid && s_axil.wready;
    assign ar_hs = s_axil.arvalid && s_axil.arready;

    // A write commits on the edge that completes the AW/W pair; a fresh beat
    // bypasses its buffer so commit needs no extra cycle.
    assign commit  = (aw_hs || w_hs) && (aw_hs || aw_held_q) && (w_hs || w_held_q);
    assign wr_addr = aw_hs ? s_axil.awaddr : awaddr_q;
    assign wr_data = w_hs ? s_axil.wdata : wdata_q;
    assign wr_strb = w_hs ? s_axil.wstrb : wstrb_q;
    assign wr_idx  = wr_addr[ADDR_W-1:2];
    assign wr_map  = wr_idx < IW'(6);

    assign rd_addr = s_axil.araddr;
    assign rd_idx  = rd_addr[ADDR_W-1:2];
    assign rd_map  = rd_idx < IW'(6);

`ifdef DMA_CSR_WSTRB_EN
    assign wmask    = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    assign start_en = wr_strb[0];
    logic unused_addr;
    assign unused_addr = ^{wr_addr[1:0], rd_addr[1:0]};
`else
    assign wmask    = '1;
    assign start_en = 1'b1;
    logic unused_addr;
    assign unused_addr = ^{wr_addr[1:0], rd_addr[1:0], wr_strb};
`endif

    // Write decode: next register values, start request and write response
    always_comb begin
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        burst_d     = burst_q;
        irq_en_d    = irq_en_q;
        start_d     = 1'b0;
        clr_status  = 1'b0;
        set_err_cmd = 1'b0;
        wr_resp     = RESP_OKAY;
        if (commit) begin
            if (!wr_map) begin
                wr_resp = RESP_SLVERR;
            end else begin
                case (wr_idx[2:0])
                    3'd0: if (dma_busy) wr_resp = RESP_SLVERR;
                          else src_d = (src_q & ~wmask) | (wr_data & wmask);
                    3'd1: if (dma_busy) wr_resp = RESP_SLVERR;
                          else dst_d = (dst_q & ~wmask) | (wr_data & wmask);
                    3'd2: if (dma_busy) wr_resp = RESP_SLVERR;
                          else len_d = (len_q & ~wmask) | (wr_data & wmask);
                    3'd5: if (dma_busy) wr_resp = RESP_SLVERR;
                          else burst_d = (burst_q & ~wmask[1:0]) | (wr_data[1:0] & wmask[1:0]);
                    3'd3: begin
                        if (wmask[1]) irq_en_d = wr_data[1];
                        if (wr_data[0] && start_en) begin
                            if (dma_busy)              wr_resp = RESP_SLVERR;
                            else if (burst_q == 2'b11) set_err_cmd = 1'b1;
                            else begin
                                clr_status = 1'b1;
                                start_d    = 1'b1;
                            end
                        end
                    end
                    default: wr_resp = RESP_SLVERR;  // STATUS is read-only
                endcase
            end
        end
        // Engine events win over a same-edge clear from start
        done_d = dma_done | (done_q & ~clr_status);
        err_d  = dma_err | set_err_cmd | (err_q & ~clr_status);
    end

    // Read mux: snapshot of current (pre-write) register contents
    always_comb begin
        rd_val  = '0;
        rd_resp = RESP_OKAY;
        if (!rd_map) begin
            rd_resp = RESP_SLVERR;
        end else begin
            case (rd_idx[2:0])
                3'd0:    rd_val = src_q;
                3'd1:    rd_val = dst_q;
                3'd2:    rd_val = len_q;
                3'd3:    rd_val = {30'd0, irq_en_q, 1'b0};
                3'd4:    rd_val = {30'd0, err_q, done_q};
                3'd5:    rd_val = {30'd0, burst_q};
                default: rd_resp = RESP_SLVERR;
            endcase
        end
    end

    // State update: registers, channel buffers, responses
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            burst_q   <= 2'b01;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
            start_q   <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            burst_q  <= burst_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            irq_q    <= irq_en_d & done_d;
            start_q  <= start_d;

            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    awaddr_q  <= s_axil.awaddr;
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= s_axil.wdata;
                    wstrb_q  <= s_axil.wstrb;
                end
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (bvalid_q && s_axil.bready) begin
                bvalid_q <= 1'b0;
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
                rresp_q  <= rd_resp;
            end else if (rvalid_q && s_axil.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dma_csr_slave.sv
// Directed bench for dma_csr_slave: register map, start/irq behaviour,
// busy/burst error paths, unmapped accesses and back-pressure.
module tb_dma_csr_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dma_src, dma_dst, dma_len;
    logic [1:0]  dma_burst;
    logic        dma_start;
    logic        dma_busy = 1'b0;
    logic        dma_done = 1'b0;
    logic        dma_err  = 1'b0;
    logic        irq;

    int passed = 0;
    int total  = 0;
    int start_cnt = 0;
    logic start_at_b;

    dma_csr_slave_if #(.ADDR_W(8)) s_axil ();

    dma_csr_slave #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axil    (s_axil),
        .dma_src   (dma_src),
        .dma_dst   (dma_dst),
        .dma_len   (dma_len),
        .dma_burst (dma_burst),
        .dma_start (dma_start),
        .dma_busy  (dma_busy),
        .dma_done  (dma_done),
        .dma_err   (dma_err),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dma_start) start_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // AW offered from cycle aw_dly, W from cycle w_dly; returns BRESP
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        int cyc = 0;
        int waited = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge clk);
            s_axil.awaddr  = a;
            s_axil.wdata   = d;
            s_axil.wstrb   = s;
            s_axil.awvalid = !aw_done && (cyc >= aw_dly);
            s_axil.wvalid  = !w_done && (cyc >= w_dly);
            if (s_axil.awvalid && s_axil.awready) aw_done = 1;
            if (s_axil.wvalid && s_axil.wready)   w_done  = 1;
            cyc++;
        end
        @(negedge clk);
        s_axil.awvalid = 1'b0;
        s_axil.wvalid  = 1'b0;
        start_at_b = dma_start;
        chk("bvalid_latency", {31'd0, s_axil.bvalid}, 32'd1);
        while (!s_axil.bvalid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        resp = s_axil.bresp;
        s_axil.bready = 1'b1;
        @(negedge clk);
        s_axil.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] data, output logic [1:0] resp);
        int waited = 0;
        @(negedge clk);
        s_axil.araddr  = a;
        s_axil.arvalid = 1'b1;
        while (!s_axil.arready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        s_axil.arvalid = 1'b0;
        chk("rvalid_latency", {31'd0, s_axil.rvalid}, 32'd1);
        data = s_axil.rdata;
        resp = s_axil.rresp;
        s_axil.rready = 1'b1;
        @(negedge clk);
        s_axil.rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int s0;

        s_axil.awaddr = '0; s_axil.awvalid = 0; s_axil.wdata = '0; s_axil.wstrb = 4'hF;
        s_axil.wvalid = 0;  s_axil.bready = 0;  s_axil.araddr = '0; s_axil.arvalid = 0;
        s_axil.rready = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ready", {29'd0, s_axil.awready, s_axil.wready, s_axil.arready}, 32'h7);
        chk("rst_valid", {30'd0, s_axil.bvalid, s_axil.rvalid}, 32'h0);
        chk("rst_outs", {28'd0, dma_burst, dma_start, irq}, 32'h4);
        chk("rst_src", dma_src, 32'h0);
        chk("rst_rdata", s_axil.rdata, 32'h0);

`ifdef DMA_CSR_WSTRB_EN
        axi_write(8'h00, 32'hAABBCCDD, 4'h2, 0, 0, resp);
        axi_read(8'h00, rd, resp);
        chk("wstrb_src", rd, 32'h0000CC00);
`endif

        // Address/data skew in both directions and together
        axi_write(8'h00, 32'h1000, 4'hF, 0, 3, resp); chk("src_resp", resp, 0);
        axi_write(8'h04, 32'h2000, 4'hF, 3, 0, resp); chk("dst_resp", resp, 0);
        axi_write(8'h08, 32'h40,   4'hF, 0, 0, resp); chk("len_resp", resp, 0);
        chk("dma_src", dma_src, 32'h1000);
        chk("dma_dst", dma_dst, 32'h2000);
        chk("dma_len", dma_len, 32'h40);

        // Start with irq enabled
        s0 = start_cnt;
        axi_write(8'h0C, 32'h3, 4'hF, 0, 0, resp);
        chk("start_resp", resp, 0);
        chk("start_with_b", {31'd0, start_at_b}, 32'd1);
        @(negedge clk);
        chk("start_one_cycle", start_cnt - s0, 32'd1);
        axi_read(8'h0C, rd, resp); chk("ctrl_read", rd, 32'h2);
        chk("irq_before_done", {31'd0, irq}, 32'd0);
        dma_done = 1'b1; @(negedge clk); dma_done = 1'b0;
        chk("irq_on_done", {31'd0, irq}, 32'd1);
        axi_read(8'h10, rd, resp); chk("status_done", rd, 32'h1);
        s0 = start_cnt;
        axi_write(8'h0C, 32'h1, 4'hF, 0, 0, resp);
        chk("restart_resp", resp, 0);
        axi_read(8'h10, rd, resp); chk("status_cleared", rd, 32'h0);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        chk("restart_pulse", start_cnt - s0, 32'd1);

        // Engine busy: writes rejected
        dma_busy = 1'b1;
        s0 = start_cnt;
        axi_write(8'h00, 32'h55, 4'hF, 0, 0, resp); chk("busy_src_resp", resp, 2'b10);
        chk("busy_src_kept", dma_src, 32'h1000);
        axi_write(8'h0C, 32'h1, 4'hF, 0, 0, resp); chk("busy_start_resp", resp, 2'b10);
        @(negedge clk);
        chk("busy_no_start", start_cnt - s0, 32'd0);
        dma_busy = 1'b0;

        // Engine error event, cleared by next start
        dma_err = 1'b1; @(negedge clk); dma_err = 1'b0;
        axi_read(8'h10, rd, resp); chk("status_err", rd, 32'h2);
        axi_write(8'h0C, 32'h1, 4'hF, 0, 0, resp);
        axi_read(8'h10, rd, resp); chk("err_cleared", rd, 32'h0);

        // Reserved burst encoding blocks start and flags err
        axi_write(8'h14, 32'h3, 4'hF, 0, 0, resp); chk("burst_resp", resp, 0);
        chk("dma_burst", {30'd0, dma_burst}, 32'h3);
        s0 = start_cnt;
        axi_write(8'h0C, 32'h1, 4'hF, 0, 0, resp); chk("burst11_resp", resp, 0);
        @(negedge clk);
        chk("burst11_no_start", start_cnt - s0, 32'd0);
        axi_read(8'h10, rd, resp); chk("burst11_status", rd, 32'h2);

        // Unmapped / read-only
        axi_read(8'h18, rd, resp); chk("unmap_rdata", rd, 32'h0); chk("unmap_rresp", resp, 2'b10);
        axi_read(8'h1C, rd, resp); chk("unmap1c_rresp", resp, 2'b10);
        axi_write(8'h10, 32'h3, 4'hF, 0, 0, resp); chk("status_wr_resp", resp, 2'b10);
        axi_read(8'h10, rd, resp); chk("status_wr_kept", rd, 32'h2);
        axi_write(8'h18, 32'h3, 4'hF, 0, 0, resp); chk("unmap_wr_resp", resp, 2'b10);

        // Concurrent write+read of LENGTH with both responses stalled
        @(negedge clk);
        s_axil.awaddr = 8'h08; s_axil.wdata = 32'h80; s_axil.wstrb = 4'hF; s_axil.araddr = 8'h08;
        s_axil.awvalid = 1; s_axil.wvalid = 1; s_axil.arvalid = 1;
        @(negedge clk);
        s_axil.awvalid = 0; s_axil.wvalid = 0; s_axil.arvalid = 0;
        chk("old_value_read", s_axil.rdata, 32'h40);
        for (int i = 0; i < 5; i++) begin
            chk("stall", {27'd0, s_axil.bvalid, s_axil.rvalid, s_axil.awready, s_axil.wready,
                          s_axil.arready}, 32'h18);
            @(negedge clk);
        end
        s_axil.bready = 1; s_axil.rready = 1;
        @(negedge clk);
        s_axil.bready = 0; s_axil.rready = 0;
        chk("drained", {30'd0, s_axil.bvalid, s_axil.rvalid}, 32'h0);
        chk("len_new", dma_len, 32'h80);

        // Reset with an address beat held drops it
        s_axil.awaddr = 8'h00; s_axil.awvalid = 1;
        @(negedge clk);
        s_axil.awvalid = 0;
        chk("aw_held", {31'd0, s_axil.awready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_aw", {31'd0, s_axil.awready}, 32'd1);
        chk("rst_mid_regs", {dma_len[29:0], dma_burst}, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1);
    end
endmodule
